// File: rtl/dice_tally.sv
// dice_tally: captures the settled dice face on each button release and keeps
// roll statistics (per-face counts, roll count, running total, overflow flag).
// Optional feature macro: DICE_TALLY_STREAK_EN adds a saturating counter of
// consecutive identical accepted results; without it `streak` is tied to 0.
module dice_tally #(
   parameter int MIN_ROLL = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        button,
   input  logic [2:0]  throw,
   input  logic        clr,
   input  logic [2:0]  face_sel,
   output logic [2:0]  result,
   output logic        result_valid,
   output logic        reject,
   output logic [7:0]  roll_count,
   output logic [10:0] total,
   output logic [7:0]  face_count,
   output logic        overflow,
   output logic [3:0]  streak
);

   typedef enum logic {IDLE, ROLLING} state_t;

   localparam logic [7:0] MIN_HOLD = 8'(MIN_ROLL);

   state_t      state_q, state_d;
   logic [7:0]  hold_q, hold_d;
   logic [2:0]  result_q, result_d;
   logic        result_valid_q, result_valid_d;
   logic        reject_q, reject_d;
   logic [7:0]  roll_count_q, roll_count_d;
   logic [10:0] total_q, total_d;
   logic [7:0]  face_cnt_q [0:5];
   logic [7:0]  face_cnt_d [0:5];
   logic        overflow_q, overflow_d;
`ifdef DICE_TALLY_STREAK_EN
   logic [3:0]  streak_q, streak_d;
`endif

   // Next-state logic: hold counting, release evaluation, statistics and clear.
   always_comb begin
      state_d        = state_q;
      hold_d         = hold_q;
      result_d       = result_q;
      result_valid_d = 1'b0;
      reject_d       = 1'b0;
      roll_count_d   = roll_count_q;
      total_d        = total_q;
      face_cnt_d     = face_cnt_q;
      overflow_d     = overflow_q;
`ifdef DICE_TALLY_STREAK_EN
      streak_d       = streak_q;
`endif
      case (state_q)
         IDLE: begin
            if (button) begin
               state_d = ROLLING;
               hold_d  = 8'd1;
            end
         end
         ROLLING: begin
            if (button) begin
               if (hold_q != 8'hFF) hold_d = hold_q + 8'd1;
            end else begin
               state_d = IDLE;
               if (hold_q < MIN_HOLD || throw == 3'd0 || throw == 3'd7) begin
                  reject_d = 1'b1;
               end else begin
                  result_d       = throw;
                  result_valid_d = 1'b1;
                  if (roll_count_q != 8'hFF) begin
                     roll_count_d = roll_count_q + 8'd1;
                     total_d      = total_q + 11'(throw);
                     for (int i = 0; i < 6; i++) begin
                        if (throw == 3'(i + 1)) face_cnt_d[i] = face_cnt_q[i] + 8'd1;
                     end
                  end else begin
                     overflow_d = 1'b1;
                  end
`ifdef DICE_TALLY_STREAK_EN
                  // A zero streak marks the first roll since reset or clear.
                  if (streak_q == 4'd0 || throw != result_q) streak_d = 4'd1;
                  else if (streak_q != 4'hF)                 streak_d = streak_q + 4'd1;
`endif
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (clr) begin
         roll_count_d = 8'd0;
         total_d      = 11'd0;
         face_cnt_d   = '{default: 8'd0};
         overflow_d   = 1'b0;
`ifdef DICE_TALLY_STREAK_EN
         streak_d     = 4'd0;
`endif
      end
   end

   // State and output registers, cleared by the asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= IDLE;
         hold_q         <= 8'd0;
         result_q       <= 3'd0;
         result_valid_q <= 1'b0;
         reject_q       <= 1'b0;
         roll_count_q   <= 8'd0;
         total_q        <= 11'd0;
         face_cnt_q     <= '{default: 8'd0};
         overflow_q     <= 1'b0;
`ifdef DICE_TALLY_STREAK_EN
         streak_q       <= 4'd0;
`endif
      end else begin
         state_q        <= state_d;
         hold_q         <= hold_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         reject_q       <= reject_d;
         roll_count_q   <= roll_count_d;
         total_q        <= total_d;
         face_cnt_q     <= face_cnt_d;
         overflow_q     <= overflow_d;
`ifdef DICE_TALLY_STREAK_EN
         streak_q       <= streak_d;
`endif
      end
   end

   // Combinational per-face read; selectors outside 1..6 read as zero.
   always_comb begin
      face_count = 8'd0;
      case (face_sel)
         3'd1:    face_count = face_cnt_q[0];
         3'd2:    face_count = face_cnt_q[1];
         3'd3:    face_count = face_cnt_q[2];
         3'd4:    face_count = face_cnt_q[3];
         3'd5:    face_count = face_cnt_q[4];
         3'd6:    face_count = face_cnt_q[5];
         default: face_count = 8'd0;
      endcase
   end

   assign result       = result_q;
   assign result_valid = result_valid_q;
   assign reject       = reject_q;
   assign roll_count   = roll_count_q;
   assign total        = total_q;
   assign overflow     = overflow_q;
`ifdef DICE_TALLY_STREAK_EN
   assign streak       = streak_q;
`else
   assign streak       = 4'd0;
`endif

endmodule
